// File: rtl/chunk_serializer.sv
// Word-to-chunk serializer with valid/ready on both sides and a last-chunk flag.
// Define SERIALIZER_LSB_FIRST_EN to emit chunks least-significant first.
module chunk_serializer #(
  parameter int INWIDTH  = 32,
  parameter int OUTWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [INWIDTH-1:0]  in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUTWIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy
);

  localparam int NCHUNK = INWIDTH / OUTWIDTH;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  if ((INWIDTH % OUTWIDTH) != 0 || OUTWIDTH > INWIDTH) begin : g_param_check
    $error("chunk_serializer: OUTWIDTH must divide INWIDTH and not exceed it");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [INWIDTH-1:0] sreg;
  logic [IW-1:0]      idx;
  logic               at_last;
  logic               in_fire;
  logic               out_fire;
  logic [OUTWIDTH-1:0] cur_chunk;
  logic [INWIDTH-1:0]  sreg_shifted;

  assign at_last  = (state == SEND) && (idx == LAST_IDX);
  // in_ready depends on out_ready combinationally so consecutive words have no bubble
  assign in_ready = (state == IDLE) || (at_last && out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef SERIALIZER_LSB_FIRST_EN
  assign cur_chunk    = sreg[OUTWIDTH-1:0];
  assign sreg_shifted = sreg >> OUTWIDTH;
`else
  assign cur_chunk    = sreg[INWIDTH-1 -: OUTWIDTH];
  assign sreg_shifted = sreg << OUTWIDTH;
`endif

  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? cur_chunk : '0;
  assign out_last  = at_last;
  assign busy      = (state == SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else if (clear) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            sreg  <= in_data;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_fire) begin
            if (!at_last) begin
              sreg <= sreg_shifted;
              idx  <= idx + IW'(1);
            end else if (in_fire) begin
              sreg <= in_data;
              idx  <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
